// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are queued in a circular FIFO and sent LSB first back-to-back.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_en,
    output logic               uart_txd,
    output logic               uart_tx_busy,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               tx_overflow
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem [DEPTH];

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 full;
    logic                 empty;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        push     = tx_en && !full;
        txd_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The line is registered, so it is derived from the state being entered.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = ^shift_d;
`endif
            default:  txd_d = 1'b1;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        ovf_d    = tx_en && full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != S_IDLE) || !empty;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign fifo_count   = count_q;
    assign tx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with BPS_CNT = 10; a line monitor decodes frames into queues.
// Frame length follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int FIFO_AW  = 4;
    localparam int BPS      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BPS;

    logic             clk;
    logic             rst_n;
    logic [7:0]       tx_data;
    logic             tx_en;
    logic             uart_txd;
    logic             uart_tx_busy;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             tx_overflow;

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_en        (tx_en),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .tx_overflow  (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmpCount = 0;
    int errCount = 0;
    int cyc = 0;
    int lowCount = 0;
    int ovfPulses = 0;

    logic [7:0] rxData [$];
    int         rxTime [$];
    logic       rxOk   [$];
    logic       rxPar  [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (uart_txd === 1'b0) lowCount++;
    always @(negedge clk) if (tx_overflow === 1'b1) ovfPulses++;

    // Line monitor: once a low is seen, sample each bit near its middle and queue the frame.
    initial begin : monitor
        logic [7:0] d;
        logic       s, p, e;
        int         t;
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                t = cyc;
                repeat (4) @(negedge clk);
                s = uart_txd;
                for (int b = 0; b < 8; b++) begin
                    repeat (BPS) @(negedge clk);
                    d[b] = uart_txd;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (BPS) @(negedge clk);
                p = uart_txd;
`endif
                repeat (BPS) @(negedge clk);
                e = uart_txd;
                rxData.push_back(d);
                rxTime.push_back(t);
                rxPar.push_back(p);
`ifdef UART_TX_PARITY_EN
                rxOk.push_back((s === 1'b0) && (e === 1'b1) && (p === ^d));
`else
                rxOk.push_back((s === 1'b0) && (e === 1'b1));
`endif
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        cmpCount++;
        assert (obs === expd) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expd);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        tx_data = d;
        tx_en   = 1'b1;
        @(posedge clk);
        #1;
        tx_en   = 1'b0;
    endtask

    task automatic clearRx();
        rxData.delete();
        rxTime.delete();
        rxOk.delete();
        rxPar.delete();
    endtask

    task automatic waitFrames(input int n, input int budget);
        int c;
        c = 0;
        while (rxData.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput("frames_received", rxData.size(), n);
    endtask

    initial begin : stimulus
        logic [7:0] burst [3];
        int ovfBase, lowBase, tEnd, c;
        burst = '{8'hA5, 8'h3C, 8'hFF};

        rst_n   = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_txd", uart_txd, 1);
        checkOutput("reset_count", fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_txd", uart_txd, 1);
        checkOutput("idle_busy", uart_tx_busy, 0);
        checkOutput("idle_empty", fifo_empty, 1);
        checkOutput("idle_full", fifo_full, 0);
        checkOutput("idle_overflow", tx_overflow, 0);

        // Single byte 0x55: start bit after the pop edge, busy through the stop bit.
        clearRx();
        applyStimulus(8'h55);
        @(negedge clk);
        checkOutput("single_count_e0", fifo_count, 1);
        checkOutput("single_busy_e0", uart_tx_busy, 1);
        checkOutput("single_txd_e0", uart_txd, 1);
        @(negedge clk);
        checkOutput("single_txd_e1", uart_txd, 0);
        checkOutput("single_count_e1", fifo_count, 0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        checkOutput("single_busy_last", uart_tx_busy, 1);
        checkOutput("single_txd_stop", uart_txd, 1);
        @(negedge clk);
        checkOutput("single_busy_done", uart_tx_busy, 0);
        checkOutput("single_frames", rxData.size(), 1);
        if (rxData.size() == 1) begin
            checkOutput("single_data", rxData[0], 8'h55);
            checkOutput("single_framing", rxOk[0], 1);
        end

        // Burst of three consecutive pushes.
        clearRx();
        tx_data = 8'hA5;
        tx_en   = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h3C;
        @(negedge clk);
        checkOutput("burst_count_e0", fifo_count, 1);
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        @(negedge clk);
        checkOutput("burst_count_e1", fifo_count, 1);
        checkOutput("burst_txd_e1", uart_txd, 0);
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        @(negedge clk);
        checkOutput("burst_count_peak", fifo_count, 2);
        waitFrames(3, 4 * FRAME_CYC);
        for (int i = 0; i < rxData.size() && i < 3; i++) begin
            checkOutput($sformatf("burst_data_%0d", i), rxData[i], burst[i]);
            checkOutput($sformatf("burst_framing_%0d", i), rxOk[i], 1);
        end
        if (rxData.size() == 3) begin
            checkOutput("burst_gap_01", rxTime[1] - rxTime[0], FRAME_CYC);
            checkOutput("burst_gap_12", rxTime[2] - rxTime[1], FRAME_CYC);
        end
        repeat (2 * BPS) @(negedge clk);
        checkOutput("burst_busy_done", uart_tx_busy, 0);

        // Overflow: 18 pushes back-to-back, the last one rejected.
        clearRx();
        ovfBase = ovfPulses;
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(8'h40 + i);
            @(posedge clk);
            #1;
        end
        checkOutput("ovf_count_16", fifo_count, 15);
        checkOutput("ovf_full_16", fifo_full, 0);
        tx_data = 8'h50;
        @(posedge clk);
        #1;
        checkOutput("ovf_full_17", fifo_full, 1);
        checkOutput("ovf_count_17", fifo_count, 16);
        checkOutput("ovf_pulse_17", tx_overflow, 0);
        tx_data = 8'h51;
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        checkOutput("ovf_pulse_18", tx_overflow, 1);
        checkOutput("ovf_count_18", fifo_count, 16);
        @(posedge clk);
        #1;
        checkOutput("ovf_pulse_end", tx_overflow, 0);
        waitFrames(17, 18 * FRAME_CYC);
        repeat (3 * FRAME_CYC) @(negedge clk);
        checkOutput("ovf_frames_total", rxData.size(), 17);
        for (int i = 0; i < rxData.size() && i < 17; i++) begin
            checkOutput($sformatf("ovf_data_%0d", i), rxData[i], 8'(8'h40 + i));
        end
        checkOutput("ovf_pulses", ovfPulses - ovfBase, 1);
        checkOutput("ovf_busy_done", uart_tx_busy, 0);

        // Reset during data bit 3 of 0x11 with two bytes still queued.
        clearRx();
        tx_data = 8'h11;
        tx_en   = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h22;
        @(posedge clk);
        #1;
        tx_data = 8'h33;
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        repeat (43) @(posedge clk);
        #2;
        checkOutput("rst_pre_txd_bit3", uart_txd, 0);
        checkOutput("rst_pre_count", fifo_count, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_txd", uart_txd, 1);
        checkOutput("rst_async_count", fifo_count, 0);
        checkOutput("rst_async_busy", uart_tx_busy, 0);
        checkOutput("rst_async_empty", fifo_empty, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lowBase = lowCount;
        repeat (3 * FRAME_CYC) @(negedge clk);
        checkOutput("rst_after_low_samples", lowCount - lowBase, 0);
        checkOutput("rst_after_busy", uart_tx_busy, 0);
        checkOutput("rst_after_txd", uart_txd, 1);
        clearRx();

        // Single 0x07: frame length depends on the parity build.
        applyStimulus(8'h07);
        c = 0;
        while (uart_tx_busy !== 1'b0 && c < 3 * FRAME_CYC) begin
            @(negedge clk);
            c++;
        end
        tEnd = cyc;
        checkOutput("par_busy_done", uart_tx_busy, 0);
        waitFrames(1, FRAME_CYC);
        if (rxData.size() == 1) begin
            checkOutput("par_data", rxData[0], 8'h07);
            checkOutput("par_framing", rxOk[0], 1);
            checkOutput("par_frame_len", tEnd - rxTime[0], FRAME_CYC);
`ifdef UART_TX_PARITY_EN
            checkOutput("par_bit", rxPar[0], 1);
`endif
        end

        // 40 bytes spaced 100 cycles apart: pointers wrap more than twice.
        clearRx();
        ovfBase = ovfPulses;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'(i));
            repeat (99) @(posedge clk);
            #1;
        end
        waitFrames(40, 40 * FRAME_CYC);
        for (int i = 0; i < rxData.size() && i < 40; i++) begin
            checkOutput($sformatf("wrap_data_%0d", i), rxData[i], 8'(i));
            checkOutput($sformatf("wrap_framing_%0d", i), rxOk[i], 1);
        end
        checkOutput("wrap_no_overflow", ovfPulses - ovfBase, 0);
        repeat (2 * FRAME_CYC) @(negedge clk);
        checkOutput("wrap_empty", fifo_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes on a single-cycle write strobe into an internal FIFO and serializes them 8N1, LSB first, with no idle gap between queued frames. It is the transmit end of the UART link. It sits where a plain transmitter would otherwise drop bytes written while busy, e.g. behind a receiver's `uart_rx_done`/`uart_rx_data` in loopback or command-response designs.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `FIFO_AW`, default 4: FIFO address width.
  - Depth = 2^FIFO_AW, so 16 by default.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `tx_data` input 8: byte to queue; sampled when `tx_en` is high.
- `tx_en` input 1: push strobe; one byte is pushed per cycle it is high.
- `uart_txd` output 1: serial line, idle high; registered.
- `uart_tx_busy` output 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_full` output 1: count == depth.
- `fifo_empty` output 1: count == 0.
- `fifo_count` output FIFO_AW+1: number of bytes queued, excluding the byte in flight.
- `tx_overflow` output 1: one-cycle pulse when a push is rejected.

## Operation
- `BPS_CNT` = CLK_FREQ / UART_BPS, using integer truncation.
  - Each serial bit lasts exactly BPS_CNT clocks.
  - The baud counter runs 0..BPS_CNT-1 and restarts on every bit boundary and on every frame start.
- FIFO:
  - Circular buffer with FIFO_AW-bit read/write pointers that wrap naturally.
  - `fifo_count` tracks push minus pop.
  - A push is accepted iff `tx_en` is high and the FIFO is not full.
  - A push while full is dropped and `tx_overflow` pulses high for 1 cycle.
    - This holds even if a pop occurs in the same cycle, because the full check uses the registered count.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - There is no bypass path; every byte passes through the FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_txd`=1. When the FIFO is non-empty, pop one byte into the shift register and go to START.
  - START: `uart_txd`=0 for BPS_CNT cycles, then go to DATA with bit index 0.
  - DATA: `uart_txd`=shift[bit index] for BPS_CNT cycles per bit, bits 0..7. After bit 7, go to STOP.
  - STOP: `uart_txd`=1 for BPS_CNT cycles. On the last cycle:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames);
    - otherwise go to IDLE.
- `uart_tx_busy` = (state != IDLE) | !fifo_empty.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, `uart_txd`=1, both pointers 0, `fifo_count`=0.
  - `fifo_empty`=1, `fifo_full`=0, `uart_tx_busy`=0, `tx_overflow`=0.
  - Shift register and baud counter cleared.
  - The partial frame is abandoned and queued bytes are discarded.

## Timing
- Latency from idle:
  - `tx_en` is sampled at edge E0.
  - The FSM pops at E1.
  - `uart_txd` falls after E1, i.e. the start bit begins 2 edges after the push.
- Frame length: 10*BPS_CNT cycles (11*BPS_CNT with parity).
- Queued frames follow with zero extra idle cycles.
- `fifo_count` and the flags update on the edge following the push or pop.
- `uart_tx_busy` deasserts on the edge ending the final stop bit.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting BPS_CNT cycles.
  - The parity bit is even parity, equal to ^byte.
  - Frame length becomes 11*BPS_CNT.
- Undefined: no PARITY state or logic; 8N1 frames only.

## Test plan
All tests use CLK_FREQ=1000000, UART_BPS=100000, so BPS_CNT=10.
- Single byte: push 0x55 at E0.
  - `uart_txd` goes low after E1.
  - Bits sampled at the middle of each 10-cycle bit: 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop).
  - `uart_tx_busy` is high from E0+1 to E1+100.
- Burst: push 0xA5, 0x3C, 0xFF on 3 consecutive cycles.
  - Three contiguous frames, 300 cycles total, with no high gap beyond the stop bits.
  - `fifo_count` peaks at 2.
- Overflow: push 18 bytes on consecutive cycles.
  - `fifo_full` asserts after the 17th push.
  - The 18th push is rejected with a single `tx_overflow` pulse.
  - Exactly 17 frames are emitted, in order.
- Reset mid-frame: assert `rst_n` low during data bit 3 with 2 bytes queued.
  - `uart_txd`=1 and `fifo_count`=0 immediately, with no clock edge needed.
  - After release: no further output; `uart_tx_busy` stays 0.
- Parity (`UART_TX_PARITY_EN` defined): push 0x07.
  - The parity bit is 1 and the frame is 110 cycles.
  - Without the macro, the same push gives a 100-cycle frame.
- Wrap-around: stream 40 bytes (0x00..0x27) with pushes spaced 100 cycles apart.
  - Pointers wrap at least twice.
  - All 40 bytes are transmitted in order, with no overflow.
